// File: rtl/sseg_scan_if.sv
// Display-side bundle of the scanning seven-segment driver: value/mode controls in, multiplexed drives out.
// The source of data and controls takes the master view; the driver takes the slave view.
interface sseg_scan_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] data;
  logic                hex_dec;
  logic                sign;
  logic                blank_lz;
  logic [DIGITS-1:0]   dp_en;
  logic [6:0]          seg;
  logic                dp;
  logic [DIGITS-1:0]   an;
  logic                busy;
  logic                ovf;

  modport master (
    output data, hex_dec, sign, blank_lz, dp_en,
    input  seg, dp, an, busy, ovf
  );

  modport slave (
    input  data, hex_dec, sign, blank_lz, dp_en,
    output seg, dp, an, busy, ovf
  );
endinterface

// File: rtl/sseg_scan.sv
// Self-scanning N-digit seven-segment driver with a free-running binary-to-BCD converter.
// Display register updates atomically at COMMIT; seg/dp/an are registered one cycle behind the digit index.
module sseg_scan #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic     clk,
  input  logic     rst,
  sseg_scan_if.slave bus
);
  localparam int W  = 4 * DIGITS;
  localparam int BW = 8 * DIGITS;
  localparam int IW = $clog2(DIGITS);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_COMMIT
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_bin;
  logic            r_hex;
  logic            r_sign;
  logic [BW-1:0]   r_bcd;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_disp;
  logic            r_dsign;
  logic            r_ovf;
  logic [RW-1:0]   r_ref;
  logic [IW-1:0]   r_idx;
  logic [6:0]      r_seg;
  logic            r_dp;
  logic [DIGITS-1:0] r_an;

  logic [BW-1:0]   w_adj;
  logic [BW-1:0]   w_bcd_nxt;
  logic [3:0]      w_nib;
  logic            w_zero_above;
  logic [6:0]      w_seg;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0:    glyph = 7'b1000000;
      4'h1:    glyph = 7'b1111001;
      4'h2:    glyph = 7'b0100100;
      4'h3:    glyph = 7'b0110000;
      4'h4:    glyph = 7'b0011001;
      4'h5:    glyph = 7'b0010010;
      4'h6:    glyph = 7'b0000010;
      4'h7:    glyph = 7'b1111000;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0010000;
      4'hA:    glyph = 7'b0001000;
      4'hB:    glyph = 7'b0000011;
      4'hC:    glyph = 7'b1000110;
      4'hD:    glyph = 7'b0100001;
      4'hE:    glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = bus.hex_dec ? S_COMMIT : S_SHIFT;
      S_SHIFT:  if (r_cnt == CW'(W - 1)) w_next = S_COMMIT;
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Double-dabble step: correct every digit >= 5 before the shift.
  always_comb begin
    w_adj = '0;
    for (int i = 0; i < 2 * DIGITS; i++) begin
      w_adj[4*i +: 4] = r_bcd[4*i +: 4] + ((r_bcd[4*i +: 4] >= 4'd5) ? 4'd3 : 4'd0);
    end
    w_bcd_nxt = (w_adj << 1) | BW'(r_bin[W-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin   <= '0;
      r_hex   <= 1'b0;
      r_sign  <= 1'b0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_disp  <= '0;
      r_dsign <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_bin  <= bus.data;
          r_hex  <= bus.hex_dec;
          r_sign <= bus.sign;
          r_bcd  <= '0;
          r_cnt  <= '0;
        end
        S_SHIFT: begin
          r_bcd <= w_bcd_nxt;
          r_bin <= {r_bin[W-2:0], 1'b0};
          r_cnt <= r_cnt + 1'b1;
        end
        S_COMMIT: begin
          r_disp  <= r_hex ? r_bin : r_bcd[W-1:0];
          r_ovf   <= ~r_hex & (|r_bcd[BW-1:W]);
          r_dsign <= r_sign & ~r_hex;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ref <= '0;
      r_idx <= '0;
    end else if (r_ref == RW'(REFRESH_DIV - 1)) begin
      r_ref <= '0;
      r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_ref <= r_ref + 1'b1;
    end
  end

  // Leading-zero test uses stored digit values only; a minus overlay does not stop blanking.
  always_comb begin
    w_nib        = r_disp[r_idx*4 +: 4];
    w_zero_above = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (j >= int'(r_idx) && r_disp[4*j +: 4] != 4'h0) w_zero_above = 1'b0;
    end
    w_seg = glyph(w_nib);
    if (r_ovf)                                                w_seg = 7'b0111111;
    else if (r_dsign && r_idx == IW'(DIGITS - 1))             w_seg = 7'b0111111;
    else if (bus.blank_lz && r_idx != '0 && w_zero_above)     w_seg = 7'b1111111;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
      r_an  <= '1;
    end else begin
      r_seg <= w_seg;
      r_dp  <= ~bus.dp_en[r_idx];
      r_an  <= ~(DIGITS'(1) << r_idx);
    end
  end

  assign bus.seg  = r_seg;
  assign bus.dp   = r_dp;
  assign bus.an   = r_an;
  assign bus.busy = (r_state != S_IDLE);
  assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_sseg_scan.sv
// Directed bench for sseg_scan with DIGITS=4, REFRESH_DIV=4; expected glyphs are hand-written constants.
module tb_sseg_scan;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  sseg_scan_if #(.DIGITS(4)) bus ();

  sseg_scan #(.DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for digit k to be driven, then returns its seg and dp.
  task automatic read_digit(input int k, output logic [6:0] s, output logic d);
    logic [3:0] want;
    logic       found;
    int         n;
    want  = ~(4'b0001 << k);
    found = 1'b0;
    n     = 0;
    s     = 7'hXX;
    d     = 1'bx;
    while (!found && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.an === want) begin
        found = 1'b1;
        s     = bus.seg;
        d     = bus.dp;
      end
    end
    check($sformatf("digit%0d_scanned", k), {31'd0, found}, 32'd1);
  endtask

  task automatic check_digits(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                              input logic [6:0] e1, input logic [6:0] e0);
    logic [6:0] s;
    logic       d;
    logic [6:0] exp_seg [4];
    exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
    for (int k = 0; k < 4; k++) begin
      read_digit(k, s, d);
      check($sformatf("%s_d%0d", tag, k), {25'd0, s}, {25'd0, exp_seg[k]});
    end
  endtask

  initial begin
    logic [6:0] s;
    logic       d;
    logic       b0;
    logic       b1;
    int         nb;
    n_cmp = 0;
    n_err = 0;
    rst          = 1'b1;
    bus.data     = '0;
    bus.hex_dec  = 1'b0;
    bus.sign     = 1'b0;
    bus.blank_lz = 1'b0;
    bus.dp_en    = '0;

    #1;
    check("rst_seg",  {25'd0, bus.seg}, 32'h7F);
    check("rst_an",   {28'd0, bus.an}, 32'hF);
    check("rst_dp",   {31'd0, bus.dp}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_ovf",  {31'd0, bus.ovf}, 32'd0);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("first_an",  {28'd0, bus.an}, 32'hE);
    check("first_seg", {25'd0, bus.seg}, 32'h40);
    repeat (3) @(negedge clk);
    check("dwell_an_E", {28'd0, bus.an}, 32'hE);
    @(negedge clk);
    check("seq_an_D", {28'd0, bus.an}, 32'hD);
    repeat (4) @(negedge clk);
    check("seq_an_B", {28'd0, bus.an}, 32'hB);
    repeat (4) @(negedge clk);
    check("seq_an_7", {28'd0, bus.an}, 32'h7);
    repeat (4) @(negedge clk);
    check("seq_an_E", {28'd0, bus.an}, 32'hE);

    // Abort a decimal conversion with reset.
    bus.data = 16'd1234;
    nb = 0;
    while (bus.busy !== 1'b1 && nb < 30) begin
      @(negedge clk);
      nb++;
    end
    check("busy_seen", {31'd0, bus.busy}, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_seg",  {25'd0, bus.seg}, 32'h7F);
    check("midrst_an",   {28'd0, bus.an}, 32'hF);
    check("midrst_dp",   {31'd0, bus.dp}, 32'd1);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("postrst_an",  {28'd0, bus.an}, 32'hE);
    check("postrst_seg", {25'd0, bus.seg}, 32'h40);

    // Decimal with leading-zero blanking.
    bus.blank_lz = 1'b1;
    repeat (40) @(negedge clk);
    check_digits("dec1234", 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001);
    check("dec1234_ovf", {31'd0, bus.ovf}, 32'd0);
    bus.data = 16'd7;
    repeat (40) @(negedge clk);
    check_digits("dec7", 7'h7F, 7'h7F, 7'h7F, 7'b1111000);

    // Hex mode.
    bus.blank_lz = 1'b0;
    bus.hex_dec  = 1'b1;
    bus.data     = 16'hA0F8;
    repeat (10) @(negedge clk);
    check_digits("hexA0F8", 7'b0001000, 7'b1000000, 7'b0001110, 7'b0000000);
    nb = 0;
    b0 = bus.busy;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b1 = bus.busy;
      if (b1 === 1'b1) nb++;
      check($sformatf("hex_busy_toggle%0d", i), {31'd0, b1}, {31'd0, ~b0});
      b0 = b1;
    end
    check("hex_busy_count", nb, 32'd4);

    // Sign with blanking, then the same stimulus in hex.
    bus.hex_dec  = 1'b0;
    bus.blank_lz = 1'b1;
    bus.sign     = 1'b1;
    bus.data     = 16'd42;
    repeat (40) @(negedge clk);
    check_digits("neg42", 7'b0111111, 7'h7F, 7'b0011001, 7'b0100100);
    bus.hex_dec = 1'b1;
    repeat (10) @(negedge clk);
    check_digits("hex42", 7'h7F, 7'h7F, 7'b0100100, 7'b0001000);

    // Overflow and the largest fitting value.
    bus.hex_dec  = 1'b0;
    bus.sign     = 1'b0;
    bus.blank_lz = 1'b0;
    bus.data     = 16'd10000;
    repeat (40) @(negedge clk);
    check("ovf_set", {31'd0, bus.ovf}, 32'd1);
    check_digits("ovf", 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111);
    bus.data = 16'd9999;
    repeat (40) @(negedge clk);
    check("ovf_clr", {31'd0, bus.ovf}, 32'd0);
    check_digits("dec9999", 7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000);

    // Decimal points.
    bus.dp_en = 4'b0101;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      read_digit(k, s, d);
      check($sformatf("dp_d%0d", k), {31'd0, d}, (k % 2 == 0) ? 32'd0 : 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
